// File: rtl/pad_fifo_pkg.sv
// pad_fifo_pkg: shared defaults and sizing helpers for the padding FIFOs.
// Used by the Q/K/V projection input paths.
package pad_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LANES      = 4;

    // Elements produced by one accepted word.
    function automatic int frame_len(
        input logic pad_en,
        input int   lanes,
        input int   pad_pre,
        input int   pad_post
    );
        return pad_en ? (pad_pre + lanes + pad_post) : lanes;
    endfunction

    // Width able to hold the values 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pad_fifo_out_reg.sv
// pad_fifo_out_reg: single-element output register with valid/ready.
// Requests a pop whenever it is empty or its element is being taken.
module pad_fifo_out_reg
    import pad_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  avail_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  ready_i,
    output logic                  pop_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    assign pop_o   = avail_i && (!valid_q || ready_i);
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // Load on pop, drop valid once the element has been taken.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (pop_o) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Output register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/pad_fifo.sv
// pad_fifo: accepts LANES-element words, streams padded single elements.
// Padding is built only when PAD_FIFO_PAD_EN is defined.
module pad_fifo
    import pad_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LANES      = DEF_LANES,
    parameter int PAD_PRE    = 2,
    parameter int PAD_POST   = 1,
    parameter int DEPTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH*LANES-1:0] in_data,
`ifdef PAD_FIFO_PAD_EN
    input  logic                        pad_en,
    input  logic [DATA_WIDTH-1:0]       pad_value,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        full,
    output logic                        empty
);

`ifdef PAD_FIFO_PAD_EN
    localparam int FMAX = frame_len(1'b1, LANES, PAD_PRE, PAD_POST);
`else
    localparam int FMAX = frame_len(1'b0, LANES, PAD_PRE, PAD_POST);
`endif
    localparam int CW = cnt_width(DEPTH);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] lane  [LANES];
    logic [DATA_WIDTH-1:0] frame [FMAX];
    logic [AW-1:0]         widx  [FMAX];
    logic [CW-1:0]         f_len;
    logic                  wr_en;
    logic                  pop;

    function automatic logic [AW-1:0] wrap_add(
        input logic [AW-1:0] base,
        input int            inc
    );
        int sum;
        sum = int'(base) + inc;
        if (sum >= DEPTH) sum = sum - DEPTH;
        return AW'(sum);
    endfunction

    assign in_ready = (CW'(DEPTH) - cnt_q) >= CW'(FMAX);
    assign wr_en    = in_valid && in_ready;
    assign full     = (cnt_q == CW'(DEPTH));
    assign empty    = (cnt_q == '0) && !out_valid;

    // Split the word into elements, MS element first, then lay out the frame.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane[j] = in_data[(LANES-1-j)*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int k = 0; k < FMAX; k++) begin
            frame[k] = '0;
        end
`ifdef PAD_FIFO_PAD_EN
        f_len = CW'(frame_len(pad_en, LANES, PAD_PRE, PAD_POST));
        if (pad_en) begin
            for (int j = 0; j < PAD_PRE; j++) frame[j] = pad_value;
            for (int j = 0; j < LANES; j++) frame[PAD_PRE+j] = lane[j];
            for (int j = 0; j < PAD_POST; j++) begin
                frame[PAD_PRE+LANES+j] = pad_value;
            end
        end else begin
            for (int j = 0; j < LANES; j++) frame[j] = lane[j];
        end
`else
        f_len = CW'(LANES);
        for (int j = 0; j < LANES; j++) frame[j] = lane[j];
`endif
    end

    // Storage slot of every frame entry, wrapped modulo DEPTH.
    always_comb begin
        for (int k = 0; k < FMAX; k++) begin
            widx[k] = wrap_add(wr_ptr_q, k);
        end
    end

    // Frame write into storage; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < FMAX; k++) begin
                if (k < int'(f_len)) mem_q[widx[k]] <= frame[k];
            end
        end
    end

    // Pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            wr_ptr_d = wrap_add(wr_ptr_q, int'(f_len));
            cnt_d    = cnt_d + f_len;
        end
        if (pop) begin
            rd_ptr_d = wrap_add(rd_ptr_q, 1);
            cnt_d    = cnt_d - CW'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    pad_fifo_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .avail_i (cnt_q != '0),
        .data_i  (mem_q[rd_ptr_q]),
        .ready_i (out_ready),
        .pop_o   (pop),
        .valid_o (out_valid),
        .data_o  (out_data)
    );

endmodule

// File: tb/tb_pad_fifo.sv
// tb_pad_fifo: directed and random checks of two pad_fifo instances
// (DEPTH 16 and 14) against a queue-based element model.
module tb_pad_fifo;

    localparam int DW   = 8;
    localparam int L    = 4;
    localparam int PRE  = 2;
    localparam int POST = 1;
`ifdef PAD_FIFO_PAD_EN
    localparam bit PADB = 1'b1;
`else
    localparam bit PADB = 1'b0;
`endif
    localparam int FMAX = PADB ? (PRE + L + POST) : L;

    logic          clk;
    logic          rst_n;
    logic          ordy;
    logic          iv   [2];
    logic [31:0]   idat [2];
    logic          pe   [2];
    logic [7:0]    pv   [2];
    logic          ir   [2];
    logic          ov   [2];
    logic [7:0]    od   [2];
    logic          fu   [2];
    logic          em   [2];

    int            errors;
    int            checks;

    logic [7:0]    mq   [2][$];
    logic [7:0]    sent [2][$];
    logic [7:0]    dlog [2][$];
    logic [7:0]    eq   [$];
    logic [7:0]    fr   [$];
    bit            ovm  [2];
    logic [7:0]    odm  [2];
    bit            accf [2];

    pad_fifo #(
        .DATA_WIDTH (DW), .LANES (L), .PAD_PRE (PRE),
        .PAD_POST (POST), .DEPTH (16)
    ) u_d16 (
        .clk (clk), .rst_n (rst_n),
        .in_valid (iv[0]), .in_ready (ir[0]), .in_data (idat[0]),
`ifdef PAD_FIFO_PAD_EN
        .pad_en (pe[0]), .pad_value (pv[0]),
`endif
        .out_valid (ov[0]), .out_ready (ordy), .out_data (od[0]),
        .full (fu[0]), .empty (em[0])
    );

    pad_fifo #(
        .DATA_WIDTH (DW), .LANES (L), .PAD_PRE (PRE),
        .PAD_POST (POST), .DEPTH (14)
    ) u_d14 (
        .clk (clk), .rst_n (rst_n),
        .in_valid (iv[1]), .in_ready (ir[1]), .in_data (idat[1]),
`ifdef PAD_FIFO_PAD_EN
        .pad_en (pe[1]), .pad_value (pv[1]),
`endif
        .out_valid (ov[1]), .out_ready (ordy), .out_data (od[1]),
        .full (fu[1]), .empty (em[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int dep(input int i);
        return (i == 0) ? 16 : 14;
    endfunction

    function automatic bit exp_ir(input int i);
        return (dep(i) - mq[i].size()) >= FMAX;
    endfunction

    function automatic bit busy();
        return mq[0].size() != 0 || mq[1].size() != 0 || ovm[0] || ovm[1];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame of one word: pads, MS..LS elements, pads.
    task automatic build(input logic [31:0] w, input bit p,
                         input logic [7:0] v);
        fr.delete();
        if (p) for (int k = 0; k < PRE; k++) fr.push_back(v);
        for (int k = L - 1; k >= 0; k--) fr.push_back(w[k*8 +: 8]);
        if (p) for (int k = 0; k < POST; k++) fr.push_back(v);
    endtask

    task automatic push_frame(input int i);
        build(idat[i], pe[i], pv[i]);
        foreach (fr[k]) begin
            mq[i].push_back(fr[k]);
            sent[i].push_back(fr[k]);
        end
    endtask

    task automatic add_exp(input logic [31:0] w, input bit p,
                           input logic [7:0] v);
        build(w, p, v);
        foreach (fr[k]) eq.push_back(fr[k]);
    endtask

    task automatic model_reset(input int i);
        mq[i].delete();
        ovm[i] = 1'b0;
        odm[i] = 8'h00;
        accf[i] = 1'b0;
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 2; i++) begin
            dlog[i].delete();
            sent[i].delete();
        end
        eq.delete();
    endtask

    // One clock: check outputs, predict the edge, advance the model.
    task automatic step();
        bit pop [2];
        bit acc [2];
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("out_valid%0d", i), ov[i], ovm[i]);
            if (ovm[i]) chk($sformatf("out_data%0d", i), od[i], odm[i]);
            chk($sformatf("in_ready%0d", i), ir[i], exp_ir(i));
            chk($sformatf("empty%0d", i), em[i],
                mq[i].size() == 0 && !ovm[i]);
            chk($sformatf("full%0d", i), fu[i], mq[i].size() == dep(i));
            if (rst_n && ovm[i] && ordy) dlog[i].push_back(od[i]);
            pop[i] = rst_n && mq[i].size() != 0 && (!ovm[i] || ordy);
            acc[i] = rst_n && iv[i] && exp_ir(i);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                model_reset(i);
            end else begin
                if (pop[i]) begin
                    odm[i] = mq[i].pop_front();
                    ovm[i] = 1'b1;
                end else if (ordy) begin
                    ovm[i] = 1'b0;
                end
                if (acc[i]) push_frame(i);
                accf[i] = acc[i];
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input int i, input logic [31:0] w, input bit p,
                        input logic [7:0] v, input int maxc,
                        output bit ok);
        iv[i]   = 1'b1;
        idat[i] = w;
        pe[i]   = PADB ? p : 1'b0;
        pv[i]   = v;
        ok      = 1'b0;
        for (int c = 0; c < maxc && !ok; c++) begin
            step();
            ok = accf[i];
        end
        if (ok) iv[i] = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        ordy  = 1'b1;
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        while (c < 400 && busy()) begin
            step();
            c++;
        end
        chk("drain_done", busy(), 0);
    endtask

    task automatic cmp_q(input string tag, input int i, input bit vs_sent);
        int n;
        n = vs_sent ? sent[i].size() : eq.size();
        chk({tag, "_len"}, dlog[i].size(), n);
        for (int k = 0; k < n && k < dlog[i].size(); k++) begin
            chk($sformatf("%s_e%0d", tag, k), dlog[i][k],
                vs_sent ? sent[i][k] : eq[k]);
        end
    endtask

    initial begin
        bit ok;
        int rem [2];
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        ordy   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; idat[i] = '0; pe[i] = 1'b0; pv[i] = '0;
            model_reset(i);
        end
        clear_logs();

        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_out_valid", ov[i], 0);
            chk("rst_out_data", od[i], 0);
            chk("rst_in_ready", ir[i], 1);
            chk("rst_empty", em[i], 1);
            chk("rst_full", fu[i], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single padded frame with latency check.
        ordy = 1'b1;
        send(0, 32'hAABBCCDD, 1'b1, 8'h00, 4, ok);
        chk("pad_accept", ok, 1);
        chk("lat_edgeN", ov[0], 0);
        step();
        chk("lat_edgeN1", ov[0], 1);
        chk("lat_first", od[0], PADB ? 8'h00 : 8'hAA);
        drain();
        add_exp(32'hAABBCCDD, PADB, 8'h00);
        cmp_q("pad_seq", 0, 1'b0);
        clear_logs();

        // Unpadded word followed by padded word with pad 0xFF.
        send(0, 32'h11223344, 1'b0, 8'hFF, 8, ok);
        chk("byp_accept", ok, 1);
        send(0, 32'h55667788, 1'b1, 8'hFF, 8, ok);
        chk("pv_accept", ok, 1);
        drain();
        add_exp(32'h11223344, 1'b0, 8'hFF);
        add_exp(32'h55667788, PADB, 8'hFF);
        cmp_q("byp_seq", 0, 1'b0);
        clear_logs();

        // Backpressure: three back-to-back words with out_ready low.
        ordy = 1'b0;
        send(0, 32'hA1B2C3D4, 1'b1, 8'h00, 4, ok);
        chk("bp_w1", ok, 1);
        send(0, 32'hE5F60718, 1'b1, 8'h00, 4, ok);
        chk("bp_w2", ok, 1);
        send(0, 32'h293A4B5C, 1'b1, 8'h00, 4, ok);
        chk("bp_w3", ok, PADB ? 0 : 1);
        chk("bp_in_ready", ir[0], PADB ? 0 : 1);
        step();
        step();
        chk("bp_hold", od[0], PADB ? 8'h00 : 8'hA1);
        ordy = 1'b1;
        for (int c = 0; c < 50 && !ok; c++) begin
            step();
            ok = accf[0];
        end
        chk("bp_w3_late", ok, 1);
        iv[0] = 1'b0;
        drain();
        chk("bp_total", dlog[0].size(), 3 * FMAX);
        cmp_q("bp_seq", 0, 1'b1);
        clear_logs();

        // Random frames on both depths with random backpressure.
        rem[0] = 20;
        rem[1] = 20;
        for (int c = 0; c < 3000 && (rem[0] > 0 || rem[1] > 0); c++) begin
            ordy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 2; i++) begin
                if (rem[i] > 0 && !iv[i]) begin
                    iv[i]   = 1'b1;
                    idat[i] = $urandom;
                    pe[i]   = PADB ? 1'($urandom_range(0, 1)) : 1'b0;
                    pv[i]   = 8'($urandom);
                end
            end
            step();
            for (int i = 0; i < 2; i++) begin
                if (accf[i]) begin
                    rem[i]--;
                    iv[i] = 1'b0;
                end
            end
        end
        chk("wrap_frames_left", rem[0] + rem[1], 0);
        drain();
        cmp_q("wrap16", 0, 1'b1);
        cmp_q("wrap14", 1, 1'b1);
        clear_logs();

        // Reset asserted mid-stream, between clock edges.
        ordy = 1'b1;
        send(0, 32'hCAFEF00D, 1'b1, 8'h5A, 4, ok);
        chk("mr_accept", ok, 1);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", ov[0], 0);
        chk("mr_out_data", od[0], 0);
        chk("mr_empty", em[0], 1);
        chk("mr_in_ready", ir[0], 1);
        chk("mr_full", fu[0], 0);
        for (int i = 0; i < 2; i++) model_reset(i);
        clear_logs();
        @(negedge clk);
        step();
        rst_n = 1'b1;
        step();
        chk("mr_empty_rel", em[0], 1);
        send(0, 32'h0F1E2D3C, 1'b1, 8'hC3, 4, ok);
        chk("mr_post_accept", ok, 1);
        drain();
        add_exp(32'h0F1E2D3C, PADB, 8'hC3);
        cmp_q("mr_seq", 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pad_fifo.md
# pad_fifo

Parametrised padding FIFO for the Q-projection input path, the next generation of the fixed 4-byte / 7-entry padding FIFO. It accepts one packed word of `LANES` elements per handshake, inserts `PAD_PRE` leading and `PAD_POST` trailing pad elements, and streams single elements to the downstream PE array. It adds ready/valid handshakes on both sides, correct modulo wrap for any `DEPTH`, and a runtime padding bypass.

## Interface
- `DATA_WIDTH`, default 8: element width in bits.
- `LANES`, default 4: elements per input word.
- `PAD_PRE`, default 2: pad elements inserted before the lanes.
- `PAD_POST`, default 1: pad elements inserted after the lanes.
- `DEPTH`, default 16: storage entries. Legal range is `DEPTH >= PAD_PRE+LANES+PAD_POST`, and need not be a power of 2.
- `clk`  in  1: clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: input word valid.
- `in_ready`  out  1: block can accept a full frame.
- `in_data`  in  `DATA_WIDTH*LANES`: packed word. The MS element is emitted first.
- `pad_en`  in  1: pad this word. Sampled with the accepted word.
- `pad_value`  in  `DATA_WIDTH`: pad element value. Sampled with the accepted word.
- `out_valid`  out  1: `out_data` is valid.
- `out_ready`  in  1: downstream accepts the element.
- `out_data`  out  `DATA_WIDTH`: output element.
- `full`  out  1: memory count equals `DEPTH`.
- `empty`  out  1: no element in memory or in the output register.

## Operation
- Frame lengths:
  - F_MAX = `PAD_PRE+LANES+PAD_POST`.
  - F = F_MAX when `pad_en`=1, else `LANES`.
- Frame order: `PAD_PRE` × `pad_value`, then `in_data` from the MS element down to the LS element, then `PAD_POST` × `pad_value`.
- `in_ready` = (`DEPTH` − mem_count) ≥ F_MAX.
  - Registered state only. There is no combinational path from `in_*`.
  - It ignores any same-cycle pop.
- Write on `in_valid && in_ready`:
  - Entry k of the frame goes to mem[(wr_ptr+k) mod `DEPTH`], for k = 0..F−1.
  - wr_ptr ← (wr_ptr+F) mod `DEPTH`.
  - Every index is reduced mod `DEPTH`, so no write lands out of range.
- Output register:
  - Pop condition: mem_count≠0 && (!`out_valid` || `out_ready`).
  - On pop: `out_data` ← mem[rd_ptr], `out_valid` ← 1, rd_ptr ← (rd_ptr+1) mod `DEPTH`.
  - Otherwise, if `out_ready` is high, `out_valid` ← 0.
- mem_count update:
  - +F on write only.
  - −1 on pop only.
  - +F−1 when a write and a pop occur in the same cycle.
  - Width is $clog2(`DEPTH`+1).
- `empty` = (mem_count==0) && !`out_valid`.
- `pad_value` and `pad_en` are held per frame. A change between frames takes effect only on the next accepted word.
- mem is not reset.

## Timing
- While `rst_n` is low, asynchronously:
  - rd_ptr, wr_ptr and mem_count are 0.
  - `out_valid`=0 and `out_data`=0.
  - `in_ready`=1, `full`=0, `empty`=1.
- Reset mid-frame discards all content. After release the block behaves exactly as after power-up.
- Latency: a word accepted at edge N gives `out_valid`=1 after edge N+1 with the first frame element. The following elements appear one per cycle while `out_ready`=1.
- Output throughput: 1 element/cycle.
- Sustained input rate: 1 word per F cycles.
- The output side holds `out_data` and `out_valid` stable while `out_valid && !out_ready`.
- The input side may hold `in_valid` with no ready dependency.

## Configuration
- `PAD_FIFO_PAD_EN` defined:
  - Padding logic, `pad_en` and `pad_value` are present.
  - F_MAX = `PAD_PRE+LANES+PAD_POST`.
- `PAD_FIFO_PAD_EN` undefined:
  - `pad_en` and `pad_value` ports are removed.
  - F = F_MAX = `LANES`, and `PAD_PRE`/`PAD_POST` are ignored.
  - The block is a plain `LANES`:1 width-converting FIFO with identical handshake and timing.

## Structure
- `pad_fifo_pkg` holds:
  - the frame-length function (`pad_en`, `LANES`, `PAD_PRE`, `PAD_POST` → F);
  - the count/pointer width function ($clog2(`DEPTH`+1));
  - the shared defaults (`DATA_WIDTH`=8, `LANES`=4).
- One sub-module, `pad_fifo_out_reg`:
  - the output register with its pop-request / valid / ready logic;
  - reused by the K/V projection FIFOs.

## Test plan
- **Reset:** hold `rst_n`=0 across a clock edge, then release → `out_valid`=0, `out_data`=0, `in_ready`=1, `empty`=1, `full`=0.
- **Padded frame:** write 0xAABBCCDD with `pad_en`=1, `pad_value`=0x00, `out_ready`=1 → stream 00,00,AA,BB,CC,DD,00 on 7 consecutive cycles, with the first `out_valid` one cycle after the accept edge.
- **Bypass and pad value:** write 0x11223344 with `pad_en`=0, then 0x55667788 with `pad_en`=1 and `pad_value`=0xFF → 11,22,33,44,FF,FF,55,66,77,88,FF.
- **Backpressure:** `out_ready`=0 and three back-to-back words → two are accepted, mem_count=13 and `in_ready`=0. The third is held and `out_data` stays 00. Raise `out_ready` → `in_ready` returns when mem_count ≤ 9, and all 21 elements emerge in order.
- **Wrap:** `DEPTH`=16 and `DEPTH`=14 instances, 20 consecutive frames with random `out_ready` → the output matches the scoreboard exactly, with no loss or duplication across pointer wrap.
- **Simultaneous and mid-reset:** a write and a pop in the same cycle → mem_count rises by 6. Assert `rst_n` mid-stream → `out_valid` falls without waiting for an edge, and the block is `empty` after release.
